// File: rtl/text_ram_writer.sv
// Write-side agent for the shared text RAM: decodes a byte stream, keeps a cursor, writes during blanking.
// Optional build macro CLEAR_ON_RESET_EN: fill the whole RAM with FILL_CHAR after every reset.
module text_ram_writer #(
    parameter int         COL_BITS  = 5,
    parameter int         ROW_BITS  = 5,
    parameter logic [7:0] FILL_CHAR = 8'h20
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [7:0]                   in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         blank,
    output logic [COL_BITS+ROW_BITS-1:0] ram_addr,
    output logic [7:0]                   ram_din,
    output logic                         ram_we,
    output logic [ROW_BITS-1:0]          cur_row,
    output logic [COL_BITS-1:0]          cur_col,
    output logic                         busy
);

    localparam int ADDR_W = COL_BITS + ROW_BITS;

    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_FF = 8'h0C;
    localparam logic [7:0] CH_CR = 8'h0D;

    typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;

`ifdef CLEAR_ON_RESET_EN
    localparam state_t RESET_STATE = CLEAR;
`else
    localparam state_t RESET_STATE = IDLE;
`endif

    state_t              state;
    state_t              state_next;
    logic                started;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   clr_cnt;
    logic [7:0]          din_q;
    logic                accept;
    logic                clearing;

    // started is low during reset and for the first cycle after it, which silences
    // both the handshake and the write strobe without waiting for a clock edge.
    assign in_ready = started && (state == IDLE);
    assign accept   = in_valid && in_ready;
    assign clearing = started && (state == CLEAR);
    assign ram_we   = started && blank && ((state == WRITE) || (state == CLEAR));
    assign busy     = (state != IDLE);
    assign ram_addr = clearing ? clr_cnt : addr_q;
    assign ram_din  = clearing ? FILL_CHAR : din_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            started <= 1'b0;
            state   <= RESET_STATE;
        end else begin
            started <= 1'b1;
            state   <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (in_data == CH_FF)
                        state_next = CLEAR;
                    else if ((in_data != CH_CR) && (in_data != CH_LF) && (in_data != CH_BS))
                        state_next = WRITE;
                end
            end
            WRITE: begin
                if (ram_we)
                    state_next = IDLE;
            end
            CLEAR: begin
                if (ram_we && (&clr_cnt))
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_row <= '0;
            cur_col <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            clr_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (in_data)
                            CH_CR: cur_col <= '0;
                            CH_LF: begin
                                cur_col <= '0;
                                cur_row <= cur_row + 1'b1;
                            end
                            CH_BS: begin
                                if (cur_col != '0)
                                    cur_col <= cur_col - 1'b1;
                            end
                            CH_FF: clr_cnt <= '0;
                            default: begin
                                din_q  <= in_data;
                                addr_q <= {cur_row, cur_col};
                            end
                        endcase
                    end
                end
                WRITE: begin
                    // Column and row wrap naturally at their power-of-two widths.
                    if (ram_we) begin
                        cur_col <= cur_col + 1'b1;
                        if (&cur_col)
                            cur_row <= cur_row + 1'b1;
                    end
                end
                CLEAR: begin
                    if (ram_we) begin
                        clr_cnt <= clr_cnt + 1'b1;
                        if (&clr_cnt) begin
                            cur_row <= '0;
                            cur_col <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_text_ram_writer.sv
// Self-checking bench for text_ram_writer: a cursor/write-queue model plus directed literal checks.
module tb_text_ram_writer;

    localparam int COLS = 32;
    localparam int ROWS = 32;

    logic       clk;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       blank;
    logic [9:0] ram_addr;
    logic [7:0] ram_din;
    logic       ram_we;
    logic [4:0] cur_row;
    logic [4:0] cur_col;
    logic       busy;

    int compared = 0;
    int failed   = 0;
    int writes_seen = 0;
    int mrow = 0;
    int mcol = 0;
    int expq[$];
    bit toggle = 0;

    text_ram_writer #(.COL_BITS(5), .ROW_BITS(5), .FILL_CHAR(8'h20)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .blank(blank), .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
        .cur_row(cur_row), .cur_col(cur_col), .busy(busy)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (toggle) blank = ~blank;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Every write the DUT makes must be the next one the model predicted.
    always @(negedge clk) begin
        if (!reset && ram_we) begin
            int e;
            writes_seen++;
            checkOutput("we_while_blank_low", blank, 1);
            if (expq.size() == 0) begin
                checkOutput("unexpected_write", 1, 0);
            end else begin
                e = expq.pop_front();
                checkOutput("wr_addr", ram_addr, e >> 8);
                checkOutput("wr_data", ram_din, e & 255);
            end
        end
    end

    task automatic modelAccept(input logic [7:0] b);
        case (b)
            8'h0D: mcol = 0;
            8'h0A: begin mcol = 0; mrow = (mrow + 1) % ROWS; end
            8'h08: if (mcol > 0) mcol = mcol - 1;
            8'h0C: begin
                for (int a = 0; a < ROWS * COLS; a++) expq.push_back(a * 256 + 'h20);
                mrow = 0;
                mcol = 0;
            end
            default: begin
                expq.push_back((mrow * COLS + mcol) * 256 + int'(b));
                mcol = mcol + 1;
                if (mcol == COLS) begin
                    mcol = 0;
                    mrow = (mrow + 1) % ROWS;
                end
            end
        endcase
    endtask

    // Returns at 2 time units after the accepting clock edge.
    task automatic applyStimulus(input logic [7:0] b);
        bit acc = 0;
        in_data  = b;
        in_valid = 1;
        for (int i = 0; i < 5000 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #2;
        end
        in_valid = 0;
        if (!acc) checkOutput("accept_timeout", 0, 1);
        else modelAccept(b);
    endtask

    task automatic waitIdle(input int limit);
        bit done = 0;
        for (int i = 0; i < limit && !done; i++) begin
            @(negedge clk);
            done = in_ready && !busy;
        end
        if (!done) checkOutput("idle_timeout", 0, 1);
        @(posedge clk);
        #2;
    endtask

    task automatic sendAndWait(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(b);
            waitIdle(100);
        end
    endtask

    task automatic checkCursor(input string name, input int row, input int col);
        checkOutput({name, "_row"}, cur_row, row);
        checkOutput({name, "_col"}, cur_col, col);
        checkOutput({name, "_model_row"}, mrow, row);
        checkOutput({name, "_model_col"}, mcol, col);
    endtask

    initial begin
        int ws0;
        bit hit;
        reset = 1; in_valid = 0; in_data = 0; blank = 1;
        @(posedge clk); #2;
        @(negedge clk);
        checkOutput("rst_we", ram_we, 0);
        checkOutput("rst_addr", ram_addr, 0);
        checkOutput("rst_din", ram_din, 0);
        checkOutput("rst_ready", in_ready, 0);
        checkOutput("rst_busy", busy, 0);
        checkCursor("rst", 0, 0);
        @(posedge clk); #2;
        reset = 0;
        @(negedge clk);
        checkOutput("first_cycle_ready", in_ready, 0);
        @(negedge clk);
        checkOutput("second_cycle_ready", in_ready, 1);
        @(posedge clk); #2;

        // Single printable byte with blank high.
        applyStimulus(8'h41);
        @(negedge clk);
        checkOutput("A_we", ram_we, 1);
        checkOutput("A_addr", ram_addr, 0);
        checkOutput("A_din", ram_din, 'h41);
        @(negedge clk);
        checkOutput("A_col", cur_col, 1);
        checkOutput("A_ready", in_ready, 1);
        @(posedge clk); #2;

        // Write held off while blank is low.
        blank = 0;
        applyStimulus(8'h42);
        ws0 = writes_seen;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("gap_we", ram_we, 0);
            checkOutput("gap_ready", in_ready, 0);
        end
        @(posedge clk); #2;
        blank = 1;
        waitIdle(100);
        checkOutput("gap_one_write", writes_seen - ws0, 1);
        checkCursor("after_B", 0, 2);

        // Row-end advance and full-screen wrap.
        sendAndWait(8'h0D, 1);
        sendAndWait(8'h0A, 3);
        sendAndWait(8'h61, 31);
        checkCursor("pre_Z", 3, 31);
        applyStimulus(8'h5A);
        @(negedge clk);
        checkOutput("Z_addr", ram_addr, 127);
        checkOutput("Z_din", ram_din, 'h5A);
        waitIdle(100);
        checkCursor("post_Z", 4, 0);
        sendAndWait(8'h0A, 27);
        sendAndWait(8'h62, 31);
        checkCursor("pre_wrap", 31, 31);
        sendAndWait(8'h63, 1);
        checkCursor("post_wrap", 0, 0);

        // Control characters never write.
        sendAndWait(8'h0A, 5);
        sendAndWait(8'h64, 7);
        checkCursor("at_5_7", 5, 7);
        ws0 = writes_seen;
        sendAndWait(8'h0D, 1);
        checkCursor("CR", 5, 0);
        sendAndWait(8'h0A, 1);
        checkCursor("LF", 6, 0);
        sendAndWait(8'h08, 1);
        checkCursor("BS_at_0", 6, 0);
        checkOutput("ctrl_no_write", writes_seen - ws0, 0);
        sendAndWait(8'h65, 1);
        sendAndWait(8'h08, 1);
        checkCursor("BS_at_1", 6, 0);

        // Full clear with blank toggling every cycle.
        ws0 = writes_seen;
        toggle = 1;
        applyStimulus(8'h0C);
        waitIdle(5000);
        toggle = 0;
        blank = 1;
        checkOutput("clear_writes", writes_seen - ws0, 1024);
        checkOutput("clear_queue_left", expq.size(), 0);
        checkCursor("clear", 0, 0);
        checkOutput("clear_ready", in_ready, 1);

        // Reset in the middle of a clear.
        ws0 = writes_seen;
        applyStimulus(8'h0C);
        hit = 0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            @(negedge clk);
            hit = (writes_seen - ws0) >= 500;
        end
        if (!hit) checkOutput("clear500_timeout", 0, 1);
        @(posedge clk); #2;
        reset = 1;
        #1;
        checkOutput("midclr_we", ram_we, 0);
        checkOutput("midclr_busy", busy, 0);
        checkOutput("midclr_addr", ram_addr, 0);
        expq.delete();
        mrow = 0;
        mcol = 0;
        @(posedge clk); #2;
        reset = 0;
        @(negedge clk);
        checkOutput("midclr_first_ready", in_ready, 0);
        @(negedge clk);
        checkOutput("midclr_ready", in_ready, 1);
        checkCursor("midclr", 0, 0);
        @(posedge clk); #2;
        sendAndWait(8'h51, 1);
        checkOutput("final_queue_left", expq.size(), 0);
        checkCursor("final", 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
